// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: round-robin owner of the single memory refill port shared by
// the instruction cache (requester 0) and the data cache (requester 1).
module mem_refill_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic              valid0,
  output logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic              valid1,
  output logic [DATA_W-1:0] data1,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_ack,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_data,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t            r_state;
  logic [1:0]        r_grant;
  logic              r_m_req;
  logic [ADDR_W-1:0] r_m_addr;
  logic              r_err;
  logic              r_last;
  logic [CW-1:0]     r_cnt;
  logic              w_pick1;
  logic              w_last_beat;
  // r_last is the previous owner; on a tie the other requester wins
  assign w_pick1     = req1 & (~req0 | ~r_last);
  assign w_last_beat = m_valid & (r_cnt == CW'(BEATS - 1));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= 2'b00;
      r_m_req  <= 1'b0;
      r_m_addr <= '0;
      r_err    <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_err <= (m_valid & (r_state == IDLE)) | (m_ack & (r_state != REQ));
      case (r_state)
        IDLE: if (req0 | req1) begin
          r_state  <= REQ;
          r_grant  <= w_pick1 ? 2'b10 : 2'b01;
          r_m_addr <= w_pick1 ? addr1 : addr0;
          r_m_req  <= 1'b1;
          r_cnt    <= '0;
        end
        REQ: if (m_ack) begin
          r_state <= DATA;
          r_m_req <= 1'b0;
          r_cnt   <= CW'(m_valid);
        end
        DATA: if (m_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last_beat) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_last  <= r_grant[1];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // acks outside REQ are protocol errors and never reach a requester
  assign ack0   = m_ack & (r_state == REQ) & r_grant[0];
  assign ack1   = m_ack & (r_state == REQ) & r_grant[1];
  assign valid0 = m_valid & r_grant[0];
  assign valid1 = m_valid & r_grant[1];
  assign data0  = m_data;
  assign data1  = m_data;
  assign m_req  = r_m_req;
  assign m_addr = r_m_addr;
  assign grant  = r_grant;
  assign busy   = r_state != IDLE;
  assign err    = r_err;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: directed vector table, corner sequences and a random run
// checked against a transaction-level model of the refill arbiter.
module tb_mem_refill_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int NB = 4;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          m_ack = 1'b0, m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          ack0, ack1, valid0, valid1, m_req, busy, err;
  logic [DW-1:0] data0, data1;
  logic [AW-1:0] m_addr;
  logic [1:0]    grant;
  int checks = 0;
  int fails = 0;

  mem_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .ack0(ack0), .valid0(valid0), .data0(data0),
    .req1(req1), .addr1(addr1), .ack1(ack1), .valid1(valid1), .data1(data1),
    .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack), .m_valid(m_valid), .m_data(m_data),
    .grant(grant), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // transaction model: owner -1 = free; acked = address accepted; beats = beats received
  int            md_own, md_beats, md_last;
  bit            md_acked, md_err;
  logic [AW-1:0] md_addr;

  function automatic int pick(logic r0, logic r1, int last);
    return (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_own <= -1; md_acked <= 1'b0; md_beats <= 0; md_last <= 1; md_err <= 1'b0; md_addr <= '0;
    end else if (md_own < 0) begin
      md_err <= m_valid | m_ack;
      if (req0 | req1) begin
        md_own   <= pick(req0, req1, md_last);
        md_addr  <= (pick(req0, req1, md_last) == 1) ? addr1 : addr0;
        md_acked <= 1'b0;
        md_beats <= 0;
      end
    end else if (!md_acked) begin
      md_err <= 1'b0;
      if (m_ack) begin
        md_acked <= 1'b1;
        md_beats <= m_valid ? 1 : 0;
      end
    end else begin
      md_err <= m_ack;
      if (m_valid) begin
        md_beats <= md_beats + 1;
        if (md_beats + 1 == NB) begin
          md_own  <= -1;
          md_last <= md_own;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r0, input logic r1, input logic a, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    req0 = r0; req1 = r1; m_ack = a; m_valid = v; m_data = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req0 = 0; req1 = 0; m_ack = 0; m_valid = 0;
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic serve(input logic [1:0] eg);
    step(1, 1, 1, 0, 0);
    chk("alt_grant", grant, eg);
    chk("alt_ack", {ack1, ack0}, eg);
    for (int i = 0; i < NB; i++) begin
      step(1, 1, 0, 1, i);
      chk("alt_valid", {valid1, valid0}, eg);
    end
    step(1, 1, 0, 0, 0);
    chk("alt_idle_grant", grant, 2'b00);
    chk("alt_idle_busy", busy, 0);
  endtask

  // fields: r0 r1 ack valid | m_data | grant | m_req ack0 ack1 valid0 valid1 busy err
  typedef struct packed {
    logic [3:0]  in;
    logic [31:0] d;
    logic [1:0]  g;
    logic [6:0]  o;
  } vec_t;
  vec_t tv [24];

  initial begin
    bit dr0, dr1;
    logic [1:0] eg;
    tv[0]  = {4'b1000, 32'h0,  2'b00, 7'b0000000};
    tv[1]  = {4'b1000, 32'h0,  2'b01, 7'b1000010};
    tv[2]  = {4'b1000, 32'h0,  2'b01, 7'b1000010};
    tv[3]  = {4'b1000, 32'h0,  2'b01, 7'b1000010};
    tv[4]  = {4'b1010, 32'h0,  2'b01, 7'b1100010};
    tv[5]  = {4'b0001, 32'h11, 2'b01, 7'b0001010};
    tv[6]  = {4'b0001, 32'h22, 2'b01, 7'b0001010};
    tv[7]  = {4'b0001, 32'h33, 2'b01, 7'b0001010};
    tv[8]  = {4'b0001, 32'h44, 2'b01, 7'b0001010};
    tv[9]  = {4'b0000, 32'h0,  2'b00, 7'b0000000};
    tv[10] = {4'b0001, 32'h55, 2'b00, 7'b0000000};
    tv[11] = {4'b0000, 32'h0,  2'b00, 7'b0000001};
    tv[12] = {4'b0010, 32'h0,  2'b00, 7'b0000000};
    tv[13] = {4'b0000, 32'h0,  2'b00, 7'b0000001};
    tv[14] = {4'b0100, 32'h0,  2'b00, 7'b0000000};
    tv[15] = {4'b0111, 32'hA1, 2'b10, 7'b1010110};
    tv[16] = {4'b0000, 32'h0,  2'b10, 7'b0000010};
    tv[17] = {4'b0001, 32'hA2, 2'b10, 7'b0000110};
    tv[18] = {4'b0000, 32'h0,  2'b10, 7'b0000010};
    tv[19] = {4'b0001, 32'hA3, 2'b10, 7'b0000110};
    tv[20] = {4'b0000, 32'h0,  2'b10, 7'b0000010};
    tv[21] = {4'b0001, 32'hA4, 2'b10, 7'b0000110};
    tv[22] = {4'b0000, 32'h0,  2'b00, 7'b0000000};
    tv[23] = {4'b0000, 32'h0,  2'b00, 7'b0000000};

    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ack_valid", {ack0, ack1, valid0, valid1}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    addr0 = 20'h1A2B4;
    addr1 = 20'h0BEEF;

    for (int i = 0; i < 24; i++) begin
      step(tv[i].in[3], tv[i].in[2], tv[i].in[1], tv[i].in[0], tv[i].d);
      chk($sformatf("tv%0d_grant", i), grant, tv[i].g);
      chk($sformatf("tv%0d_outs", i), {m_req, ack0, ack1, valid0, valid1, busy, err}, tv[i].o);
      chk($sformatf("tv%0d_data", i), {data0 ^ tv[i].d, data1 ^ tv[i].d}, 0);
      if (tv[i].o[6]) chk($sformatf("tv%0d_m_addr", i), m_addr, tv[i].g[1] ? addr1 : addr0);
    end

    // strict alternation under continuous contention
    do_reset();
    step(1, 1, 0, 0, 0);
    chk("alt_start_grant", grant, 2'b00);
    serve(2'b01);
    serve(2'b10);
    serve(2'b01);
    serve(2'b10);

    // req1 arrives while requester 0 is receiving data
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("late_ack0", ack0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 1, 2);
    chk("late_m_req", m_req, 0);
    chk("late_grant_hold", grant, 2'b01);
    step(0, 1, 0, 1, 3);
    step(0, 1, 0, 1, 4);
    step(0, 1, 0, 0, 0);
    chk("late_l1_grant", grant, 2'b00);
    chk("late_l1_busy", busy, 0);
    step(0, 1, 0, 0, 0);
    chk("late_l2_grant", grant, 2'b10);
    chk("late_l2_m_req", m_req, 1);
    chk("late_l2_m_addr", m_addr, addr1);
    step(0, 1, 1, 0, 0);
    chk("late_ack1", ack1, 1);
    for (int i = 0; i < NB; i++) step(0, 0, 0, 1, i);
    step(0, 0, 0, 0, 0);
    chk("late_done_busy", busy, 0);

    // reset during DATA after two beats, then a stray beat and a fresh refill
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 2);
    @(negedge clk);
    m_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid0", valid0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_valid0", valid0, 0);
    step(1, 0, 0, 0, 0);
    chk("post_rst_err", err, 1);
    chk("post_rst_grant", grant, 2'b00);
    step(1, 0, 1, 0, 0);
    chk("post_rst_ack0", ack0, 1);
    for (int i = 0; i < NB; i++) begin
      step(0, 0, 0, 1, 32'h100 + i);
      chk("post_rst_valid", valid0, 1);
      chk("post_rst_busy", busy, 1);
    end
    step(0, 0, 0, 0, 0);
    chk("post_rst_done", busy, 0);
    chk("post_rst_err_clear", err, 0);

    // random traffic against the model
    do_reset();
    dr0 = 0; dr1 = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (dr0) begin req0 = 0; dr0 = 0; end
      else if (!req0 && $urandom_range(3) == 0) begin req0 = 1; addr0 = AW'($urandom()); end
      else if (req0 && $urandom_range(31) == 0) req0 = 0;
      if (dr1) begin req1 = 0; dr1 = 0; end
      else if (!req1 && $urandom_range(3) == 0) begin req1 = 1; addr1 = AW'($urandom()); end
      else if (req1 && $urandom_range(31) == 0) req1 = 0;
      if (md_own < 0) begin
        m_ack   = $urandom_range(39) == 0;
        m_valid = $urandom_range(39) == 0;
      end else if (!md_acked) begin
        m_ack   = $urandom_range(2) == 0;
        m_valid = m_ack && $urandom_range(1) == 0;
      end else begin
        m_ack   = 1'b0;
        m_valid = $urandom_range(1) == 0;
      end
      m_data = $urandom();
      #1;
      eg = md_own < 0 ? 2'b00 : (md_own == 0 ? 2'b01 : 2'b10);
      chk("rnd_grant", grant, eg);
      chk("rnd_m_req", m_req, md_own >= 0 && !md_acked);
      chk("rnd_busy", busy, md_own >= 0);
      chk("rnd_err", err, md_err);
      chk("rnd_ack", {ack1, ack0}, {m_ack && md_own == 1 && !md_acked, m_ack && md_own == 0 && !md_acked});
      chk("rnd_valid", {valid1, valid0}, {m_valid && md_own == 1, m_valid && md_own == 0});
      chk("rnd_data", data0 ^ data1 ^ m_data, m_data);
      if (md_own >= 0 && !md_acked) chk("rnd_m_addr", m_addr, md_addr);
      if (m_ack && md_own == 0 && !md_acked) dr0 = 1;
      if (m_ack && md_own == 1 && !md_acked) dr1 = 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Shares the single backing-memory refill port between two cache requesters: requester 0 (instruction cache) and requester 1 (data cache). Both use the cache miss protocol: req/addr held until a one-cycle ack, then BEATS one-cycle valid data beats. The block selects one requester at a time, round-robin. It forwards the captured address to memory and steers ack/valid back to the granted requester. It holds the grant until the full line has returned.

## Interface
- ADDR_W, 20, refill address width
- DATA_W, 32, beat data width
- BEATS, 4, data beats per refill (power of two, ≥2)

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 refill request, held until ack0
- addr0  in  ADDR_W  requester 0 line address, stable while req0
- ack0  out  1  address accepted for requester 0 (one cycle)
- valid0  out  1  data beat valid for requester 0
- data0  out  DATA_W  beat data (m_data broadcast)
- req1, addr1, ack1, valid1, data1: same as requester 0, for requester 1
- m_req  out  1  memory request, registered
- m_addr  out  ADDR_W  memory address, registered
- m_ack  in  1  memory accepted address (one cycle)
- m_valid  in  1  memory data beat valid
- m_data  in  DATA_W  memory beat data
- grant  out  2  one-hot current owner, 00 when idle
- busy  out  1  transaction in progress (state ≠ IDLE)
- err  out  1  one-cycle pulse on protocol violation

## Operation
- States: IDLE, REQ, DATA.
- IDLE, neither req: stay; grant=00, m_req=0.
- IDLE, one req: → REQ.
  - grant ← that requester.
  - m_addr ← its addr.
  - m_req ← 1.
- IDLE, both req: grant the requester not granted last (last_owner flag). Otherwise as single req.
- REQ: hold m_req=1 and m_addr until m_ack sampled high, then → DATA and m_req ← 0.
  - ackX = m_ack & grant[X], combinational.
- DATA: beat counter (log2 BEATS bits, cleared on entry to REQ) increments per m_valid.
  - validX = m_valid & grant[X], combinational.
  - dataX = m_data always.
  - On the BEATS-th valid: → IDLE; grant ← 00; last_owner ← owner.
- m_valid coincident with m_ack in REQ counts as beat 0 and is forwarded.
- Requests are committed at grant. If the owner drops req before ack, the transaction still completes and beats are still forwarded.
- Non-owner req is ignored until the arbiter returns to IDLE. There is no preemption.
- err pulses (registered, one cycle) on any of:
  - m_valid in IDLE (beat dropped, not forwarded);
  - m_ack outside REQ (ignored).
- Reset values:
  - state IDLE; grant 00; m_req 0; m_addr 0; err 0; busy 0; beat count 0;
  - last_owner = 1, so requester 0 wins the first tie.
  - ack/valid are 0 through gating.

## Timing
- Cycle N: req sampled in IDLE. Cycle N+1: m_req=1, m_addr valid, grant valid, busy=1.
- Minimum grant latency is 1 cycle; m_req and m_addr are registered.
- If m_ack is sampled at cycle M, m_req is low from M+1.
- The last beat at cycle L: grant=00 and busy=0 at L+1. The next grant can appear at L+2 at the earliest, so there is one IDLE cycle between transactions.
- Continuous back-to-back contention alternates owners strictly.
- Reset asserted mid-transaction: all outputs take reset values immediately. Beats in flight after reset release produce err and are dropped.

## Test plan
- Single req0, addr0=0x1A2B4; m_ack 3 cycles after m_req; 4 consecutive m_valid beats 0x11..0x44.
  - m_req rises at N+1 with m_addr=0x1A2B4.
  - ack0 is pulsed once.
  - valid0 ×4 with data 0x11..0x44.
  - ack1/valid1 stay 0.
  - busy falls after beat 4.
- req0 and req1 asserted together from reset: grant=01 first. After completion with both still asserting: grant=10, then 01 again, strictly alternating.
- req1 arrives while requester 0 is in DATA: no m_req change. grant=10 exactly 2 cycles after requester 0's last beat.
- m_ack and m_valid in the same cycle, then 3 gapped beats (idle cycles between): 4 beats forwarded, the first together with the ack. Returns to IDLE after the 4th.
- m_valid in IDLE, and m_ack with no request: err pulses 1 cycle each. Nothing is forwarded and state stays IDLE.
- reset_n low during DATA after 2 beats: grant=00, m_req=0, busy=0 immediately. After release, the next req0 is served normally with the beat count restarting at 0.
